// File: rtl/led_blink_sched.sv
// led_blink_sched: multi-channel LED blink scheduler driven by one shared prescaler.
// Each channel runs an IDLE/ON/OFF sequencer programmed through a valid/ready config port.
module led_blink_sched #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COUNT_W  = 8,
  localparam int unsigned CW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [PERIOD_W-1:0] cfg_on,
  input  logic [PERIOD_W-1:0] cfg_off,
  input  logic [COUNT_W-1:0]  cfg_count,
  input  logic [NUM_LEDS-1:0] stop_req,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] busy,
  output logic [NUM_LEDS-1:0] done
);

  localparam int unsigned PS_W  = $clog2(PRESCALE);
  localparam int unsigned CNX_W = COUNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  logic [PS_W-1:0]     ps_cnt;
  logic                tick_c;
  logic                accept_c;

  state_t              state_q   [NUM_LEDS];
  state_t              state_d   [NUM_LEDS];
  logic [PERIOD_W-1:0] phase_q   [NUM_LEDS];
  logic [PERIOD_W-1:0] phase_d   [NUM_LEDS];
  logic [PERIOD_W-1:0] on_len_q  [NUM_LEDS];
  logic [PERIOD_W-1:0] on_len_d  [NUM_LEDS];
  logic [PERIOD_W-1:0] off_len_q [NUM_LEDS];
  logic [PERIOD_W-1:0] off_len_d [NUM_LEDS];
  logic [COUNT_W-1:0]  target_q  [NUM_LEDS];
  logic [COUNT_W-1:0]  target_d  [NUM_LEDS];
  logic [COUNT_W-1:0]  cyc_q     [NUM_LEDS];
  logic [COUNT_W-1:0]  cyc_d     [NUM_LEDS];
  logic [NUM_LEDS-1:0] done_d;

  assign tick_c   = (ps_cnt == PS_W'(PRESCALE - 1));
  assign accept_c = cfg_valid & cfg_ready;

  // Shared free-running prescaler; tick marks the last cycle of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick_c) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // Config port opens one edge after reset release and stays open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
    end
  end

  // Per-channel state and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(NUM_LEDS); c++) begin
        state_q[c]   <= S_IDLE;
        phase_q[c]   <= '0;
        on_len_q[c]  <= '0;
        off_len_q[c] <= '0;
        target_q[c]  <= '0;
        cyc_q[c]     <= '0;
      end
    end else begin
      for (int c = 0; c < int'(NUM_LEDS); c++) begin
        state_q[c]   <= state_d[c];
        phase_q[c]   <= phase_d[c];
        on_len_q[c]  <= on_len_d[c];
        off_len_q[c] <= off_len_d[c];
        target_q[c]  <= target_d[c];
        cyc_q[c]     <= cyc_d[c];
      end
    end
  end

  // Next-state: stop_req beats config, config beats tick.
  always_comb begin
    logic             hit;
    logic [CNX_W-1:0] cyc_nxt;
    hit     = 1'b0;
    cyc_nxt = '0;
    for (int c = 0; c < int'(NUM_LEDS); c++) begin
      state_d[c]   = state_q[c];
      phase_d[c]   = phase_q[c];
      on_len_d[c]  = on_len_q[c];
      off_len_d[c] = off_len_q[c];
      target_d[c]  = target_q[c];
      cyc_d[c]     = cyc_q[c];
      done_d[c]    = 1'b0;
      hit          = accept_c && (cfg_chan == CW'(c));
      cyc_nxt      = {1'b0, cyc_q[c]} + CNX_W'(1);
      if (stop_req[c]) begin
        state_d[c] = S_IDLE;
      end else if (hit) begin
        if (cfg_on == '0) begin
          state_d[c] = S_IDLE;
        end else begin
          state_d[c]   = S_ON;
          phase_d[c]   = cfg_on;
          on_len_d[c]  = cfg_on;
          off_len_d[c] = cfg_off;
          target_d[c]  = cfg_count;
          cyc_d[c]     = '0;
        end
      end else if (tick_c) begin
        case (state_q[c])
          S_ON: begin
            // A zero off-length holds the LED on indefinitely.
            if (off_len_q[c] != '0) begin
              if (phase_q[c] == PERIOD_W'(1)) begin
                state_d[c] = S_OFF;
                phase_d[c] = off_len_q[c];
              end else begin
                phase_d[c] = phase_q[c] - PERIOD_W'(1);
              end
            end
          end
          S_OFF: begin
            if (phase_q[c] == PERIOD_W'(1)) begin
              cyc_d[c] = cyc_nxt[COUNT_W] ? '1 : cyc_nxt[COUNT_W-1:0];
              if ((target_q[c] != '0) && (cyc_nxt == {1'b0, target_q[c]})) begin
                state_d[c] = S_IDLE;
                done_d[c]  = 1'b1;
              end else begin
                state_d[c] = S_ON;
                phase_d[c] = on_len_q[c];
              end
            end else begin
              phase_d[c] = phase_q[c] - PERIOD_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Registered LED drive, busy and done pulse follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led  <= '0;
      busy <= '0;
      done <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_LEDS); c++) begin
        led[c]  <= (state_d[c] == S_ON);
        busy[c] <= (state_d[c] != S_IDLE);
      end
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_led_blink_sched.sv
// tb_led_blink_sched: randomized and directed checks of led_blink_sched against a
// tick-count model (LED state derived from ticks elapsed since the accepting edge).
module tb_led_blink_sched;

  localparam int NL = 4;
  localparam int PS = 4;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_on;
  logic [7:0] cfg_off;
  logic [3:0] cfg_count;
  logic [3:0] stop_req;
  logic [3:0] led;
  logic [3:0] busy;
  logic [3:0] done;

  logic       cfg_ready_o;
  logic [2:0] led_o;
  logic [2:0] busy_o;
  logic [2:0] done_o;

  int errors;
  int checks;

  led_blink_sched #(.NUM_LEDS(4), .PRESCALE(4), .PERIOD_W(8), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_count(cfg_count),
    .stop_req(stop_req), .led(led), .busy(busy), .done(done)
  );

  // Three-channel instance so that an out-of-range channel number is expressible.
  led_blink_sched #(.NUM_LEDS(3), .PRESCALE(4), .PERIOD_W(8), .COUNT_W(4)) dut_odd (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_o),
    .cfg_chan(cfg_chan), .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_count(cfg_count),
    .stop_req(stop_req[2:0]), .led(led_o), .busy(busy_o), .done(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ticks arrive every PS edges after reset release.
  int       m_edges;
  bit       m_ready;
  bit       m_act [NL];
  int       m_on  [NL];
  int       m_off [NL];
  int       m_tgt [NL];
  int       m_k   [NL];
  logic [3:0] m_done;
  logic [3:0] exp_led;
  logic [3:0] exp_busy;
  logic       m_tick;

  assign m_tick = (((m_edges + 1) % PS) == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_ready <= 1'b0;
      m_done  <= '0;
      for (int c = 0; c < NL; c++) begin
        m_act[c] <= 1'b0;
        m_k[c]   <= 0;
      end
    end else begin
      m_edges <= m_edges + 1;
      m_ready <= 1'b1;
      for (int c = 0; c < NL; c++) begin
        m_done[c] <= 1'b0;
        if (stop_req[c]) begin
          m_act[c] <= 1'b0;
        end else if (cfg_valid && m_ready && (int'(cfg_chan) == c)) begin
          m_act[c] <= (cfg_on != 0);
          m_on[c]  <= int'(cfg_on);
          m_off[c] <= int'(cfg_off);
          m_tgt[c] <= int'(cfg_count);
          m_k[c]   <= 0;
        end else if (m_act[c] && m_tick) begin
          m_k[c] <= m_k[c] + 1;
          if (m_off[c] != 0 && m_tgt[c] != 0 &&
              (m_k[c] + 1) == m_tgt[c] * (m_on[c] + m_off[c])) begin
            m_act[c]  <= 1'b0;
            m_done[c] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    exp_led  = '0;
    exp_busy = '0;
    for (int c = 0; c < NL; c++) begin
      if (m_act[c]) begin
        exp_busy[c] = 1'b1;
        if (m_off[c] == 0) exp_led[c] = 1'b1;
        else exp_led[c] = ((m_k[c] % (m_on[c] + m_off[c])) < m_on[c]);
      end
    end
  end

  task automatic set_cfg(input int ch, input int on, input int off, input int cnt);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_on    = 8'(on);
    cfg_off   = 8'(off);
    cfg_count = 4'(cnt);
  endtask

  task automatic clr_inputs();
    cfg_valid = 1'b0;
    stop_req  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_inputs();
    cfg_chan = '0; cfg_on = '0; cfg_off = '0; cfg_count = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({led, busy, done} !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: got %h required 000", {led, busy, done});
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b required 0", cfg_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b required 0", cfg_ready);
    end
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge: got %b required 1", cfg_ready);
    end
  endtask

  task automatic test_counted();
    int pulses;
    pulses = 0;
    set_cfg(0, 2, 1, 3);
    @(negedge clk);
    clr_inputs();
    checks++;
    if (led[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL counted_start: led0=%b busy0=%b required 1 1", led[0], busy[0]);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({led, busy, done} !== {exp_led, exp_busy, m_done}) begin
        errors++;
        $display("FAIL counted_cycle%0d: got %h required %h", i, {led, busy, done},
                 {exp_led, exp_busy, m_done});
      end
      if (done[0] === 1'b1) begin
        pulses++;
        checks++;
        if (busy[0] !== 1'b0 || led[0] !== 1'b0) begin
          errors++; $display("FAIL counted_done_edge: busy0=%b led0=%b required 0 0", busy[0], led[0]);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL counted_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_forever();
    int toggles;
    int dones;
    logic prev;
    toggles = 0;
    dones   = 0;
    set_cfg(1, 1, 1, 0);
    @(negedge clk);
    clr_inputs();
    prev = led[1];
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      checks++;
      if ({led, busy, done} !== {exp_led, exp_busy, m_done}) begin
        errors++;
        $display("FAIL forever_cycle%0d: got %h required %h", i, {led, busy, done},
                 {exp_led, exp_busy, m_done});
      end
      if (led[1] !== prev) toggles++;
      if (done[1] === 1'b1) dones++;
      prev = led[1];
    end
    checks++;
    if (toggles < 50) begin
      errors++; $display("FAIL forever_toggles: got %0d required >=50", toggles);
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL forever_done: got %0d pulses required 0", dones);
    end
  endtask

  task automatic test_stop();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_led[1]) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL stop_wait: channel 1 never on, got %b required 1", led[1]);
    end
    stop_req = 4'b0010;
    @(negedge clk);
    clr_inputs();
    checks++;
    if ({led[1], busy[1], done[1]} !== 3'b000) begin
      errors++; $display("FAIL stop_mid_on: got %b required 000", {led[1], busy[1], done[1]});
    end
    set_cfg(1, 2, 1, 0);
    stop_req = 4'b0010;
    @(negedge clk);
    clr_inputs();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy[1] !== 1'b0 || led[1] !== 1'b0 ||
          {led, busy, done} !== {exp_led, exp_busy, m_done}) begin
        errors++;
        $display("FAIL stop_with_cfg%0d: got %h required %h", i, {led, busy, done},
                 {exp_led, exp_busy, m_done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tick_accept();
    int on_cycles;
    on_cycles = 0;
    for (int i = 0; i < PS && !m_tick; i++) @(negedge clk);
    set_cfg(2, 3, 2, 1);
    @(negedge clk);
    clr_inputs();
    for (int i = 0; i < 30; i++) begin
      checks++;
      if ({led, busy, done} !== {exp_led, exp_busy, m_done}) begin
        errors++;
        $display("FAIL tick_accept_cycle%0d: got %h required %h", i, {led, busy, done},
                 {exp_led, exp_busy, m_done});
      end
      if (led[2] === 1'b1) on_cycles++;
      @(negedge clk);
    end
    checks++;
    if (on_cycles !== 3 * PS) begin
      errors++; $display("FAIL tick_accept_on_len: got %0d cycles required %0d", on_cycles, 3 * PS);
    end
    set_cfg(3, 1, 0, 2);
    @(negedge clk);
    clr_inputs();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (led[3] !== 1'b1 || done[3] !== 1'b0) begin
        errors++; $display("FAIL steady_on%0d: led3=%b done3=%b required 1 0", i, led[3], done[3]);
      end
      @(negedge clk);
    end
    set_cfg(3, 0, 0, 0);
    @(negedge clk);
    clr_inputs();
    checks++;
    if ({led[3], busy[3], done[3]} !== 3'b000) begin
      errors++; $display("FAIL cfg_on_zero: got %b required 000", {led[3], busy[3], done[3]});
    end
  endtask

  task automatic test_bad_chan();
    stop_req = 4'b0111;
    @(negedge clk);
    clr_inputs();
    set_cfg(3, 2, 2, 0);
    @(negedge clk);
    clr_inputs();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({led_o, busy_o, done_o} !== 9'h000 || cfg_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL bad_chan%0d: got %h ready=%b required 000 ready=1", i,
                 {led_o, busy_o, done_o}, cfg_ready_o);
      end
      @(negedge clk);
    end
    set_cfg(2, 2, 2, 0);
    @(negedge clk);
    clr_inputs();
    checks++;
    if (led_o !== 3'b100 || busy_o !== 3'b100) begin
      errors++; $display("FAIL odd_valid_chan: led=%b busy=%b required 100 100", led_o, busy_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      clr_inputs();
      if ($urandom_range(0, 7) == 0)
        set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int c = 0; c < NL; c++)
        if ($urandom_range(0, 59) == 0) stop_req[c] = 1'b1;
      @(negedge clk);
      checks++;
      if ({led, busy, done} !== {exp_led, exp_busy, m_done} || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h ready=%b required %h ready=1", i,
                 {led, busy, done}, cfg_ready, {exp_led, exp_busy, m_done});
      end
    end
    clr_inputs();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < NL; c++) begin
      set_cfg(c, 2, 2, 2);
      @(negedge clk);
    end
    clr_inputs();
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 4'hF) begin
      errors++; $display("FAIL pre_reset_busy: got %b required 1111", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({led, busy, done} !== 12'h000 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h ready=%b required 000 ready=0", {led, busy, done}, cfg_ready);
    end
    @(negedge clk);
    checks++;
    if ({led, busy, done} !== 12'h000) begin
      errors++; $display("FAIL reset_held: got %h required 000", {led, busy, done});
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({led, busy, done} !== {exp_led, exp_busy, m_done} || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset: got %h ready=%b required %h ready=1", {led, busy, done},
                 cfg_ready, {exp_led, exp_busy, m_done});
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_counted();
    test_forever();
    test_stop();
    test_tick_accept();
    test_bad_chan();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
